// File: rtl/pmem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pmem_rr_arbiter
// Description : Round-robin arbiter sharing one cacheline-level physical
//               memory port among N_REQ cache-side requesters. One request is
//               latched per grant, driven to memory until pmem_resp, then the
//               completion is routed back and priority rotates.
// Revision    : 1.0 - initial release
// ============================================================================
module pmem_rr_arbiter #(
   parameter int N_REQ  = 3,
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0][ADDR_W-1:0] req_address,
   input  logic [N_REQ-1:0]             req_read,
   input  logic [N_REQ-1:0]             req_write,
   input  logic [N_REQ-1:0][LINE_W-1:0] req_wdata,
   output logic [LINE_W-1:0]            req_rdata,
   output logic [N_REQ-1:0]             req_resp,
   output logic [ADDR_W-1:0]            pmem_address,
   output logic                         pmem_read,
   output logic                         pmem_write,
   output logic [LINE_W-1:0]            pmem_wdata,
   input  logic [LINE_W-1:0]            pmem_rdata,
   input  logic                         pmem_resp,
   output logic [$clog2(N_REQ)-1:0]     grant_idx
);

   localparam int              c_GW   = $clog2(N_REQ);
   localparam logic [c_GW-1:0] c_LAST = c_GW'(N_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_grant;
   logic              w_complete;

   logic [N_REQ-1:0]  w_valid;
   logic              w_any;
   logic [c_GW-1:0]   w_win;
   logic [c_GW-1:0]   w_cand;

   logic [c_GW-1:0]   r_last_grant;
   logic [c_GW-1:0]   r_grant_idx;
   logic [ADDR_W-1:0] r_pmem_address;
   logic [LINE_W-1:0] r_pmem_wdata;
   logic              r_pmem_read;
   logic              r_pmem_write;

   // A requester is asking when either op line is high; write dominates later.
   assign w_valid = req_read | req_write;
   assign w_any   = |w_valid;

   // Rotating search: walk candidates from farthest to nearest after the last
   // grant so the nearest valid one (first upward, with wrap) is kept last.
   always_comb begin
      w_win  = '0;
      w_cand = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         w_cand = c_GW'((int'(r_last_grant) + k) % N_REQ);
         if (w_valid[w_cand]) begin
            w_win = w_cand;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; DONE is a single dead cycle with no arbitration, and
   // pmem_resp outside BUSY is ignored.
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_complete  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_nxt = S_BUSY;
               w_grant     = 1'b1;
            end
         end
         S_BUSY: begin
            if (pmem_resp) begin
               w_state_nxt = S_DONE;
               w_complete  = 1'b1;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Latch the winner and its operands on a grant; drop the op on completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_grant   <= c_LAST;
         r_grant_idx    <= '0;
         r_pmem_address <= '0;
         r_pmem_wdata   <= '0;
         r_pmem_read    <= 1'b0;
         r_pmem_write   <= 1'b0;
      end else if (w_grant) begin
         r_last_grant   <= w_win;
         r_grant_idx    <= w_win;
         r_pmem_address <= req_address[w_win];
         r_pmem_wdata   <= req_wdata[w_win];
         r_pmem_write   <= req_write[w_win];
         r_pmem_read    <= ~req_write[w_win];
      end else if (w_complete) begin
         r_pmem_read    <= 1'b0;
         r_pmem_write   <= 1'b0;
      end
   end

   // Completion pulse goes to the current owner in the pmem_resp cycle.
   always_comb begin
      req_resp = '0;
      if (w_complete) begin
         req_resp[r_grant_idx] = 1'b1;
      end
   end

   assign req_rdata    = pmem_rdata;
   assign pmem_address = r_pmem_address;
   assign pmem_wdata   = r_pmem_wdata;
   assign pmem_read    = r_pmem_read;
   assign pmem_write   = r_pmem_write;
   assign grant_idx    = r_grant_idx;

endmodule
`default_nettype wire
